// File: rtl/inst_encoder_pkg.sv
// Shared constants for the instruction encoder: request type codes (same numbering as the
// control decoder), MIPS opcode/func fields and the loader FSM state type.
package inst_encoder_pkg;

    localparam logic [3:0] TYPE_LUI   = 4'd1;
    localparam logic [3:0] TYPE_ADDIU = 4'd2;
    localparam logic [3:0] TYPE_ADD   = 4'd3;
    localparam logic [3:0] TYPE_SUB   = 4'd4;
    localparam logic [3:0] TYPE_LW    = 4'd5;
    localparam logic [3:0] TYPE_SW    = 4'd6;
    localparam logic [3:0] TYPE_BEQ   = 4'd7;
    localparam logic [3:0] TYPE_J     = 4'd8;
    localparam logic [3:0] TYPE_ORI   = 4'd9;
    localparam logic [3:0] TYPE_DIVU  = 4'd10;
    localparam logic [3:0] TYPE_ADDU  = 4'd11;
    localparam logic [3:0] TYPE_SLL   = 4'd12;
    localparam logic [3:0] TYPE_SRL   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/inst_encoder_encode_comb.sv
// Purely combinational field packer: request type + operand fields -> 32-bit MIPS word,
// with a flag for the reserved type codes (0, 14, 15) that have no encoding.
module inst_encode_comb
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  req_type,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        reserved
);

    always_comb begin
        word     = 32'd0;
        reserved = 1'b0;
        case (req_type)
            TYPE_ADD:   word = {OP_RTYPE, rs, rt, rd, shamt, FN_ADD};
            TYPE_SUB:   word = {OP_RTYPE, rs, rt, rd, shamt, FN_SUB};
            TYPE_ADDU:  word = {OP_RTYPE, rs, rt, rd, shamt, FN_ADDU};
            // divu writes HI/LO, so the rd and shamt slots are architecturally zero
            TYPE_DIVU:  word = {OP_RTYPE, rs, rt, 5'd0, 5'd0, FN_DIVU};
            TYPE_SLL:   word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
            TYPE_SRL:   word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
            TYPE_LUI:   word = {OP_LUI, 5'd0, rt, imm};
            TYPE_ADDIU: word = {OP_ADDIU, rs, rt, imm};
            TYPE_ORI:   word = {OP_ORI, rs, rt, imm};
            TYPE_LW:    word = {OP_LW, rs, rt, imm};
            TYPE_SW:    word = {OP_SW, rs, rt, imm};
            TYPE_BEQ:   word = {OP_BEQ, rs, rt, imm};
            TYPE_J:     word = {OP_J, target};
            default:    reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder/loader: accepts encode requests, streams the words into imem at
// auto-incrementing addresses through a single registered valid/ready output stage.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int MAX_WORDS = 256,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic                err_q, err_d;
    logic                fin_pend_q, fin_pend_d;

    logic [31:0]         enc_word;
    logic                enc_reserved;
    logic                accept;
    logic                write_done;

    inst_encode_comb u_encode (
        .req_type (req_type),
        .rs       (req_rs),
        .rt       (req_rt),
        .rd       (req_rd),
        .shamt    (req_shamt),
        .imm      (req_imm),
        .target   (req_target),
        .word     (enc_word),
        .reserved (enc_reserved)
    );

    // Once a finish is waiting on an in-flight write, stop taking new work so the session can close.
    assign req_ready  = (state_q == ST_RUN) & ~fin_pend_q & (~we_q | imem_ready)
                      & (issued_q < MAX_CNT);
    assign accept     = req_valid & req_ready;
    assign write_done = we_q & imem_ready;

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign full       = (count_q == MAX_CNT);
    assign err        = err_q;
    assign word_count = count_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        issued_d   = issued_q;
        err_d      = err_q;
        fin_pend_d = fin_pend_q;

        if (start) begin
            state_d    = ST_RUN;
            we_d       = 1'b0;
            addr_d     = base_addr & ~ADDR_W'(3);
            count_d    = '0;
            issued_d   = '0;
            err_d      = 1'b0;
            fin_pend_d = 1'b0;
        end else begin
            if (write_done) begin
                we_d    = 1'b0;
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + CNT_W'(1);
            end
            // Reserved types are consumed so the loader never stalls on them, but nothing is written.
            if (accept) begin
                if (enc_reserved) begin
                    err_d = 1'b1;
                end else begin
                    we_d     = 1'b1;
                    wdata_d  = enc_word;
                    issued_d = issued_q + CNT_W'(1);
                end
            end

            case (state_q)
                ST_RUN, ST_FULL: begin
                    if (finish | fin_pend_q) begin
                        if (!we_d) begin
                            state_d    = ST_IDLE;
                            fin_pend_d = 1'b0;
                        end else begin
                            fin_pend_d = 1'b1;
                        end
                    end else if (state_q == ST_RUN && count_d == MAX_CNT) begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            fin_pend_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
            fin_pend_q <= fin_pend_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios followed by random traffic, all
// compared against a transaction-level model of the loader session.
module tb_inst_encoder;

    localparam int AW = 32;
    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    typedef struct {
        logic [3:0]  t;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tg;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n, start, finish, req_valid, imem_ready;
    logic [AW-1:0] base_addr;
    logic [3:0]    req_type;
    logic [4:0]    req_rs, req_rt, req_rd, req_shamt;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          req_ready, imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [CW-1:0] word_count;

    inst_encoder #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .req_target(req_target), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .full(full), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Session model: 0 idle, 1 loading, 2 full.
    int          m_st = 0;
    int          m_count = 0;
    int          m_issued = 0;
    bit          m_err = 1'b0;
    bit          m_fin = 1'b0;
    logic [31:0] m_base = 32'd0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    req_t        rq[$];
    bit          last_acc;

    function automatic logic [31:0] ref_enc(input logic [3:0] t, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sh, input logic [15:0] imm,
                                            input logic [25:0] tg, output bit rsv);
        logic [31:0] f_rs, f_rt, f_rd, f_sh, f_imm, r;
        f_rs  = 32'(rs) << 21;
        f_rt  = 32'(rt) << 16;
        f_rd  = 32'(rd) << 11;
        f_sh  = 32'(sh) << 6;
        f_imm = 32'(imm);
        rsv   = 1'b0;
        r     = 32'd0;
        case (t)
            4'd1:  r = (32'd15 << 26) + f_rt + f_imm;
            4'd2:  r = (32'd9 << 26) + f_rs + f_rt + f_imm;
            4'd3:  r = f_rs + f_rt + f_rd + f_sh + 32'd32;
            4'd4:  r = f_rs + f_rt + f_rd + f_sh + 32'd34;
            4'd5:  r = (32'd35 << 26) + f_rs + f_rt + f_imm;
            4'd6:  r = (32'd43 << 26) + f_rs + f_rt + f_imm;
            4'd7:  r = (32'd4 << 26) + f_rs + f_rt + f_imm;
            4'd8:  r = (32'd2 << 26) + 32'(tg);
            4'd9:  r = (32'd13 << 26) + f_rs + f_rt + f_imm;
            4'd10: r = f_rs + f_rt + 32'd27;
            4'd11: r = f_rs + f_rt + f_rd + f_sh + 32'd33;
            4'd12: r = f_rt + f_rd + f_sh;
            4'd13: r = f_rt + f_rd + f_sh + 32'd2;
            default: rsv = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_count = 0; m_issued = 0; m_err = 1'b0; m_fin = 1'b0;
        q_addr.delete(); q_data.delete();
    endtask

    // One clock: check outputs on the falling edge, then advance the model past the rising edge.
    task automatic tick();
        bit          acc, wr, rsv, exp_rdy;
        logic [31:0] enc;
        @(negedge clk);
        exp_rdy = (m_st == 1) && !m_fin && (q_addr.size() == 0 || imem_ready) && (m_issued < MW);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("imem_we", 32'(imem_we), 32'(q_addr.size() != 0));
        if (q_addr.size() != 0) begin
            chk("imem_addr", imem_addr, q_addr[0]);
            chk("imem_wdata", imem_wdata, q_data[0]);
        end
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == MW));
        chk("err", 32'(err), 32'(m_err));
        acc = req_valid && exp_rdy;
        wr  = (q_addr.size() != 0) && imem_ready;
        if (imem_we && imem_ready) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cyc);
        end
        enc = ref_enc(req_type, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, rsv);
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        if (start) begin
            model_reset();
            m_st = 1;
            m_base = {base_addr[31:2], 2'b00};
        end else begin
            if (wr) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                m_count++;
            end
            if (acc) begin
                if (rsv) m_err = 1'b1;
                else begin
                    q_addr.push_back(m_base + 32'(4 * m_issued));
                    q_data.push_back(enc);
                    m_issued++;
                end
            end
            if (m_st != 0) begin
                if (finish || m_fin) begin
                    if (q_addr.size() == 0) begin m_st = 0; m_fin = 1'b0; end
                    else m_fin = 1'b1;
                end else if (m_st == 1 && m_count == MW) m_st = 2;
            end
        end
    endtask

    task automatic set_req(input req_t r);
        req_type = r.t; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
        req_shamt = r.sh; req_imm = r.imm; req_target = r.tg;
    endtask

    task automatic pump(input int n);
        for (int k = 0; k < n; k++) begin
            if (rq.size() != 0) begin set_req(rq[0]); req_valid = 1'b1; end
            else req_valid = 1'b0;
            tick();
            if (last_acc) void'(rq.pop_front());
        end
        req_valid = 1'b0;
    endtask

    task automatic restart(input logic [31:0] b);
        start = 1'b1; base_addr = b; req_valid = 1'b0;
        tick();
        start = 1'b0;
        log_addr.delete(); log_data.delete(); log_cyc.delete(); rq.delete();
    endtask

    function automatic req_t mk(input logic [3:0] t, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [25:0] tg);
        req_t r;
        r.t = t; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh; r.imm = imm; r.tg = tg;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
        base_addr = '0;
        set_req(mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_full_err", {30'd0, full, err}, 32'd0);
        rst_n = 1'b1;

        // 1: single addiu
        restart(32'h400);
        rq.push_back(mk(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0));
        imem_ready = 1'b0;
        pump(1);
        chk("t1_we", 32'(imem_we), 32'd1);
        chk("t1_addr", imem_addr, 32'h400);
        chk("t1_wdata", imem_wdata, 32'h24220005);
        imem_ready = 1'b1;
        pump(1);
        chk("t1_count", 32'(word_count), 32'd1);

        // 2: back-to-back add, lui, j
        restart(32'h400);
        rq.push_back(mk(4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0));
        rq.push_back(mk(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0));
        rq.push_back(mk(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100));
        pump(5);
        chk("t2_nwr", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) begin
            chk("t2_w0", log_data[0], 32'h00221820);
            chk("t2_w1", log_data[1], 32'h3C081234);
            chk("t2_w2", log_data[2], 32'h08000100);
            chk("t2_a2", log_addr[2], 32'h408);
            chk("t2_nobubble", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
        end

        // 3: backpressure mid-stream
        restart(32'h200);
        for (int i = 0; i < 4; i++)
            rq.push_back(mk(4'd11, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'd0, 26'd0));
        pump(2);
        imem_ready = 1'b0;
        pump(3);
        imem_ready = 1'b1;
        pump(5);
        chk("t3_nwr", 32'(log_data.size()), 32'd4);
        if (log_data.size() == 4) begin
            chk("t3_a3", log_addr[3], 32'h20C);
            chk("t3_w3", log_data[3], 32'h00642821);
        end

        // 4: reserved type between two sll
        restart(32'h800);
        rq.push_back(mk(4'd12, 5'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0));
        rq.push_back(mk(4'd14, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0));
        rq.push_back(mk(4'd12, 5'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0));
        pump(6);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_nwr", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk("t4_w1", log_data[1], 32'h00021900);
            chk("t4_a1", log_addr[1], 32'h804);
        end
        chk("t4_next_addr", imem_addr, 32'h808);

        // 5: fill to MAX_WORDS, fifth request stalls, finish returns to idle
        restart(32'h0);
        for (int i = 0; i < 5; i++)
            rq.push_back(mk(4'd9, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 26'd0));
        pump(8);
        chk("t5_nwr", 32'(log_data.size()), 32'd4);
        chk("t5_full", 32'(full), 32'd1);
        set_req(rq[0]);
        req_valid = 1'b1;
        #1;
        chk("t5_stall", 32'(req_ready), 32'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("t5_idle_ready", 32'(req_ready), 32'd0);

        // 6: async reset while a write is pending
        restart(32'hC00);
        rq.push_back(mk(4'd2, 5'd3, 5'd4, 5'd0, 5'd0, 16'h7777, 26'd0));
        imem_ready = 1'b0;
        pump(2);
        chk("t6_pending", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we", 32'(imem_we), 32'd0);
        chk("t6_addr", imem_addr, 32'd0);
        chk("t6_wdata", imem_wdata, 32'd0);
        chk("t6_misc", {28'd0, word_count, err}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ready = 1'b1;
        restart(32'hC00);
        rq.push_back(mk(4'd5, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'd0));
        pump(3);
        chk("t6_resume_n", 32'(log_data.size()), 32'd1);
        if (log_data.size() == 1) chk("t6_resume_a", log_addr[0], 32'hC00);

        // address wrap and low-bit masking of base
        restart(32'hFFFF_FFFB);
        for (int i = 0; i < 4; i++)
            rq.push_back(mk(4'd6, 5'd5, 5'd6, 5'd0, 5'd0, 16'hABCD, 26'd0));
        pump(6);
        chk("wrap_n", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            chk("wrap_a0", log_addr[0], 32'hFFFF_FFF8);
            chk("wrap_a2", log_addr[2], 32'h0);
        end

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            start  = ($urandom_range(0, 59) == 0) || (m_st != 1 && $urandom_range(0, 5) == 0);
            finish = ($urandom_range(0, 39) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            imem_ready = ($urandom_range(0, 9) < 7);
            req_type   = 4'($urandom);
            req_rs     = 5'($urandom);
            req_rt     = 5'($urandom);
            req_rd     = 5'($urandom);
            req_shamt  = 5'($urandom);
            req_imm    = 16'($urandom);
            req_target = 26'($urandom);
            tick();
        end
        start = 1'b0; finish = 1'b0; req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
